// File: rtl/wb_burst_read_master.sv
// Wishbone B3 burst read initiator: fetches a linear block of 32-bit words with
// incrementing bursts and presents them on a show-ahead valid/ready stream.
// A burst is launched only when the output FIFO can absorb all of it, so ACKs
// are never back-pressured.
// Optional feature macro: RDMASTER_PAGE_SPLIT_EN -- keeps every burst inside
// one 1 KiB address page.
module wb_burst_read_master #(
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned FIFO_AW   = 4
) (
   input  logic        wb_clk,
   input  logic        wb_rst_n,
   input  logic        start_i,
   input  logic [31:0] base_adr_i,
   input  logic [15:0] word_cnt_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] wbm_adr_o,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   input  logic        wbm_rty_i,
   output logic [31:0] dout_o,
   output logic        dout_valid_o,
   input  logic        dout_ready_i
);

   localparam int unsigned FifoDepth = 2 ** FIFO_AW;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StWait  = 2'd1;
   localparam logic [1:0] StBurst = 2'd2;
   localparam logic [1:0] StGap   = 2'd3;

   localparam logic [2:0] CtiIncr = 3'b010;
   localparam logic [2:0] CtiEnd  = 3'b111;

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] remain_q, remain_d;
   logic [15:0] beats_q, beats_d;
   logic [2:0]  cti_q, cti_d;
   logic        cyc_q, cyc_d;
   logic        err_q, err_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;

   logic [31:0]        fifo_mem [FifoDepth];
   logic [FIFO_AW-1:0] wptr_q, rptr_q;
   logic [FIFO_AW:0]   count_q;
   logic               push, pop;

   logic [15:0] blen;
   logic [15:0] free_cnt;
   logic        fits;

`ifdef RDMASTER_PAGE_SPLIT_EN
   logic [15:0] page_room;
`endif

   // Length of the next burst and whether the FIFO has room for all of it.
   always_comb begin
      blen = (remain_q < 16'(BURST_LEN)) ? remain_q : 16'(BURST_LEN);
`ifdef RDMASTER_PAGE_SPLIT_EN
      // Words left before the next 1 KiB boundary (1..256).
      page_room = 16'((11'd1024 - {1'b0, addr_q[9:0]}) >> 2);
      if (page_room < blen) begin
         blen = page_room;
      end
`endif
      free_cnt = 16'(FifoDepth) - 16'(count_q);
      fits     = (free_cnt >= blen);
   end

   // Transfer sequencing: next-state and control updates.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      beats_d  = beats_q;
      cti_d    = cti_q;
      cyc_d    = cyc_q;
      err_d    = err_q;
      done_d   = 1'b0;
      busy_d   = busy_q;
      push     = 1'b0;

      case (state_q)
         StIdle: begin
            // busy_o is still high during the done pulse, so starts then are ignored.
            if (start_i && !done_q) begin
               err_d = 1'b0;
               if (word_cnt_i == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d   = base_adr_i & 32'hFFFF_FFFC;
                  remain_d = word_cnt_i;
                  busy_d   = 1'b1;
                  state_d  = StWait;
               end
            end
         end

         StWait: begin
            if (fits) begin
               state_d = StBurst;
               cyc_d   = 1'b1;
               beats_d = blen;
               cti_d   = (blen == 16'd1) ? CtiEnd : CtiIncr;
            end
         end

         StBurst: begin
            if (wbm_err_i) begin
               cyc_d   = 1'b0;
               err_d   = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (wbm_rty_i) begin
               cyc_d   = 1'b0;
               state_d = StGap;
            end else if (wbm_ack_i) begin
               push     = 1'b1;
               addr_d   = addr_q + 32'd4;
               remain_d = remain_q - 16'd1;
               beats_d  = beats_q - 16'd1;
               if (beats_q == 16'd1) begin
                  cyc_d   = 1'b0;
                  state_d = StGap;
               end else if (beats_q == 16'd2) begin
                  cti_d = CtiEnd;
               end
            end
         end

         StGap: begin
            if (remain_q == 16'd0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (fits) begin
               // Room already available: skip WAIT so cyc stays low for one cycle only.
               state_d = StBurst;
               cyc_d   = 1'b1;
               beats_d = blen;
               cti_d   = (blen == 16'd1) ? CtiEnd : CtiIncr;
            end else begin
               state_d = StWait;
            end
         end
      endcase
   end

   // Control state registers; reset drops cyc/stb asynchronously.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q  <= StIdle;
         addr_q   <= 32'd0;
         remain_q <= 16'd0;
         beats_q  <= 16'd0;
         cti_q    <= 3'b000;
         cyc_q    <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         beats_q  <= beats_d;
         cti_q    <= cti_d;
         cyc_q    <= cyc_d;
         err_q    <= err_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign pop = (count_q != '0) && dout_ready_i;

   // FIFO pointers and occupancy; reset flushes the FIFO.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + FIFO_AW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + FIFO_AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage; contents need no reset since occupancy gates the output.
   always_ff @(posedge wb_clk) begin
      if (push) begin
         fifo_mem[wptr_q] <= wbm_dat_i;
      end
   end

   assign busy_o       = busy_q | done_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign wbm_adr_o    = addr_q;
   assign wbm_cti_o    = cti_q;
   assign wbm_bte_o    = 2'b00;
   assign wbm_cyc_o    = cyc_q;
   assign wbm_stb_o    = cyc_q;
   assign wbm_we_o     = 1'b0;
   assign wbm_sel_o    = 4'hF;
   assign wbm_dat_o    = 32'd0;
   assign dout_valid_o = (count_q != '0);
   assign dout_o       = dout_valid_o ? fifo_mem[rptr_q] : 32'd0;

endmodule

// File: tb/tb_wb_burst_read_master.sv
// Directed self-checking bench for wb_burst_read_master with a Wishbone slave
// model whose read data is the bitwise inverse of the word address.
module tb_wb_burst_read_master;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] base;
   logic [15:0] cnt;
   logic        ready;

   logic        busy_o, done_o, err_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i, dout_o;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
   logic        dout_valid_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Slave fault injection, indexed by the running count of presented beats.
   int beat_cnt = 0;
   bit err_arm = 0, rty_arm = 0, ack_force = 0;
   int err_at = 0, rty_at = 0;

   // Monitor state.
   bit          mon_clr = 0;
   int          occ = 0, ovf_cnt = 0, done_cnt = 0;
   int          low_run = 0, cur_len = 0, cur111 = 0;
   bit          seen = 0, prev_cyc = 0, last111 = 0, badcti = 0;
   int          blens[$];
   int          gaps[$];
   logic [31:0] starts[$];
   logic [31:0] rx[$];
   bit          ctiok[$];

   wb_burst_read_master dut (
      .wb_clk       (clk),
      .wb_rst_n     (rst_n),
      .start_i      (start),
      .base_adr_i   (base),
      .word_cnt_i   (cnt),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .wbm_adr_o    (wbm_adr_o),
      .wbm_cti_o    (wbm_cti_o),
      .wbm_bte_o    (wbm_bte_o),
      .wbm_cyc_o    (wbm_cyc_o),
      .wbm_stb_o    (wbm_stb_o),
      .wbm_we_o     (wbm_we_o),
      .wbm_sel_o    (wbm_sel_o),
      .wbm_dat_o    (wbm_dat_o),
      .wbm_dat_i    (wbm_dat_i),
      .wbm_ack_i    (wbm_ack_i),
      .wbm_err_i    (wbm_err_i),
      .wbm_rty_i    (wbm_rty_i),
      .dout_o       (dout_o),
      .dout_valid_o (dout_valid_o),
      .dout_ready_i (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign wbm_err_i = wbm_cyc_o && err_arm && (beat_cnt == err_at);
   assign wbm_rty_i = wbm_cyc_o && rty_arm && (beat_cnt == rty_at);
   assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && (ack_force || (!wbm_err_i && !wbm_rty_i));
   assign wbm_dat_i = ~wbm_adr_o;

   always @(posedge clk) begin
      if (!rst_n) beat_cnt <= 0;
      else if (wbm_cyc_o) beat_cnt <= beat_cnt + 1;
   end

   // Bus and stream monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         occ = 0;
      end else begin
         if (wbm_cyc_o && wbm_ack_i && !wbm_err_i && !wbm_rty_i) occ++;
         if (dout_valid_o && ready) occ--;
         if (occ > 16) ovf_cnt++;
      end
      if (mon_clr) begin
         blens.delete(); gaps.delete(); starts.delete(); rx.delete(); ctiok.delete();
         seen = 0; low_run = 0; done_cnt = 0;
      end else if (rst_n) begin
         if (wbm_cyc_o) begin
            if (!prev_cyc) begin
               if (seen) gaps.push_back(low_run);
               seen = 1; cur_len = 0; cur111 = 0; last111 = 0; badcti = 0;
               starts.push_back(wbm_adr_o);
            end
            low_run = 0;
            if (wbm_cti_o == 3'b111) cur111++;
            else if (wbm_cti_o != 3'b010) badcti = 1;
            last111 = (wbm_cti_o == 3'b111);
            if (wbm_ack_i && !wbm_err_i && !wbm_rty_i) cur_len++;
         end else begin
            if (prev_cyc) begin
               blens.push_back(cur_len);
               ctiok.push_back(cur111 == 1 && last111 && !badcti);
            end
            low_run++;
         end
         if (dout_valid_o && ready) rx.push_back(dout_o);
         if (done_o) done_cnt++;
      end
      prev_cyc = wbm_cyc_o;
   end

   task automatic clear_mon();
      @(posedge clk); #1 mon_clr = 1'b1;
      @(posedge clk); #1 mon_clr = 1'b0;
   endtask

   task automatic do_start(input logic [31:0] b, input logic [15:0] c);
      @(posedge clk); #1;
      base = b; cnt = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output bit ok);
      ok = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (done_o) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; base = '0; cnt = '0; ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({wbm_cyc_o, wbm_stb_o, busy_o, done_o, err_o, dout_valid_o, wbm_we_o} !== 7'd0)
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {wbm_cyc_o, wbm_stb_o, busy_o, done_o, err_o, dout_valid_o, wbm_we_o});
      else pass_cnt++;
      total_cnt++;
      if ({wbm_adr_o, wbm_dat_o, dout_o, wbm_cti_o, wbm_bte_o} !== 101'd0)
         $display("FAIL reset_data: adr=%h dat=%h dout=%h cti=%b bte=%b want all 0",
                  wbm_adr_o, wbm_dat_o, dout_o, wbm_cti_o, wbm_bte_o);
      else pass_cnt++;
      total_cnt++;
      if (wbm_sel_o !== 4'hF) $display("FAIL reset_sel: got %h want f", wbm_sel_o);
      else pass_cnt++;
      rst_n = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_bursts_20();
      bit ok;
      int bad = 0;
      ready = 1'b1;
      clear_mon();
      do_start(32'h100, 16'd20);
      wait_done(200, ok);
      total_cnt++;
      if (ok !== 1'b1) $display("FAIL t1_done_timeout: done_o not seen within 200 cycles");
      else pass_cnt++;
      idle_cycles(5);
      total_cnt++;
      if (blens.size() != 3 || blens[0] != 8 || blens[1] != 8 || blens[2] != 4)
         $display("FAIL t1_blens: got %p want '{8,8,4}", blens);
      else pass_cnt++;
      total_cnt++;
      if (starts.size() != 3 || starts[0] !== 32'h100 || starts[1] !== 32'h120 ||
          starts[2] !== 32'h140)
         $display("FAIL t1_starts: got %p want '{100,120,140}", starts);
      else pass_cnt++;
      total_cnt++;
      if (ctiok.size() != 3 || !ctiok[0] || !ctiok[1] || !ctiok[2])
         $display("FAIL t1_cti: got %p want all 1", ctiok);
      else pass_cnt++;
      total_cnt++;
      if (gaps.size() != 2 || gaps[0] != 1 || gaps[1] != 1)
         $display("FAIL t1_gaps: got %p want '{1,1}", gaps);
      else pass_cnt++;
      for (int i = 0; i < rx.size(); i++) if (rx[i] !== ~(32'h100 + 32'(4 * i))) bad++;
      total_cnt++;
      if (rx.size() != 20 || bad != 0)
         $display("FAIL t1_data: got %0d words with %0d wrong, want 20 with 0 wrong",
                  rx.size(), bad);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt != 1 || busy_o !== 1'b0)
         $display("FAIL t1_done_busy: done pulses=%0d busy=%b want 1 and 0", done_cnt, busy_o);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      bit ok;
      int bad = 0;
      ready = 1'b0;
      clear_mon();
      do_start(32'h2000, 16'd32);
      idle_cycles(60);
      total_cnt++;
      if (blens.size() != 2 || wbm_cyc_o !== 1'b0 || busy_o !== 1'b1 || dout_valid_o !== 1'b1)
         $display("FAIL t2_stall: bursts=%0d cyc=%b busy=%b valid=%b want 2 0 1 1",
                  blens.size(), wbm_cyc_o, busy_o, dout_valid_o);
      else pass_cnt++;
      ready = 1'b1;
      wait_done(300, ok);
      total_cnt++;
      if (ok !== 1'b1) $display("FAIL t2_done_timeout: done_o not seen within 300 cycles");
      else pass_cnt++;
      idle_cycles(20);
      for (int i = 0; i < rx.size(); i++) if (rx[i] !== ~(32'h2000 + 32'(4 * i))) bad++;
      total_cnt++;
      if (blens.size() != 4 || rx.size() != 32 || bad != 0)
         $display("FAIL t2_data: bursts=%0d words=%0d wrong=%0d want 4 32 0",
                  blens.size(), rx.size(), bad);
      else pass_cnt++;
   endtask

   task automatic test_error();
      bit ok;
      ready = 1'b0;
      clear_mon();
      err_at = beat_cnt + 2;
      err_arm = 1'b1;
      ack_force = 1'b1;
      do_start(32'h3000, 16'd16);
      wait_done(50, ok);
      total_cnt++;
      if (ok !== 1'b1) $display("FAIL t3_done_timeout: done_o not seen within 50 cycles");
      else pass_cnt++;
      idle_cycles(1);
      err_arm = 1'b0;
      ack_force = 1'b0;
      total_cnt++;
      if (err_o !== 1'b1 || wbm_cyc_o !== 1'b0 || busy_o !== 1'b0)
         $display("FAIL t3_err_state: err=%b cyc=%b busy=%b want 1 0 0",
                  err_o, wbm_cyc_o, busy_o);
      else pass_cnt++;
      ready = 1'b1;
      idle_cycles(5);
      total_cnt++;
      if (rx.size() != 2 || rx[0] !== ~32'h3000 || rx[1] !== ~32'h3004 || done_cnt != 1)
         $display("FAIL t3_fifo: words=%0d done pulses=%0d want 2 words of 3000,3004 and 1",
                  rx.size(), done_cnt);
      else pass_cnt++;
      do_start(32'h3100, 16'd1);
      total_cnt++;
      if (err_o !== 1'b0 || busy_o !== 1'b1)
         $display("FAIL t3_err_clear: err=%b busy=%b want 0 1", err_o, busy_o);
      else pass_cnt++;
      wait_done(50, ok);
      idle_cycles(5);
   endtask

   task automatic test_retry();
      bit ok;
      int bad = 0;
      ready = 1'b1;
      clear_mon();
      rty_at = beat_cnt + 4;
      rty_arm = 1'b1;
      ack_force = 1'b1;
      do_start(32'h4000, 16'd16);
      wait_done(200, ok);
      total_cnt++;
      if (ok !== 1'b1) $display("FAIL t4_done_timeout: done_o not seen within 200 cycles");
      else pass_cnt++;
      rty_arm = 1'b0;
      ack_force = 1'b0;
      idle_cycles(5);
      total_cnt++;
      if (blens.size() != 3 || blens[0] != 4 || blens[1] != 8 || blens[2] != 4 ||
          starts[1] !== 32'h4010 || starts[2] !== 32'h4030 || gaps[0] != 1)
         $display("FAIL t4_reissue: blens=%p starts=%p gaps=%p want '{4,8,4} 4010/4030 gap 1",
                  blens, starts, gaps);
      else pass_cnt++;
      for (int i = 0; i < rx.size(); i++) if (rx[i] !== ~(32'h4000 + 32'(4 * i))) bad++;
      total_cnt++;
      if (rx.size() != 16 || bad != 0 || err_o !== 1'b0 || !ctiok[1] || !ctiok[2])
         $display("FAIL t4_data: words=%0d wrong=%0d err=%b want 16 0 0 with good cti",
                  rx.size(), bad, err_o);
      else pass_cnt++;
   endtask

   task automatic test_short_counts();
      bit ok;
      ready = 1'b1;
      clear_mon();
      do_start(32'h5000, 16'd0);
      total_cnt++;
      if (done_o !== 1'b1 || busy_o !== 1'b1 || wbm_cyc_o !== 1'b0)
         $display("FAIL t5_zero: done=%b busy=%b cyc=%b want 1 1 0", done_o, busy_o, wbm_cyc_o);
      else pass_cnt++;
      idle_cycles(3);
      total_cnt++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || starts.size() != 0 || done_cnt != 1)
         $display("FAIL t5_zero_after: done=%b busy=%b bursts=%0d dones=%0d want 0 0 0 1",
                  done_o, busy_o, starts.size(), done_cnt);
      else pass_cnt++;
      clear_mon();
      do_start(32'h5000, 16'd1);
      wait_done(50, ok);
      idle_cycles(5);
      total_cnt++;
      if (!ok || blens.size() != 1 || blens[0] != 1 || !ctiok[0] || rx.size() != 1 ||
          rx[0] !== ~32'h5000)
         $display("FAIL t5_one: ok=%b blens=%p ctiok=%p words=%0d want 1 '{1} '{1} 1",
                  ok, blens, ctiok, rx.size());
      else pass_cnt++;
   endtask

   task automatic test_page_boundary();
      bit ok;
      ready = 1'b1;
      clear_mon();
      do_start(32'h3F8, 16'd8);
      wait_done(100, ok);
      idle_cycles(5);
`ifdef RDMASTER_PAGE_SPLIT_EN
      total_cnt++;
      if (!ok || blens.size() != 2 || blens[0] != 2 || blens[1] != 6 ||
          starts[0] !== 32'h3F8 || starts[1] !== 32'h400)
         $display("FAIL t6_split: blens=%p starts=%p want '{2,6} at 3f8,400", blens, starts);
      else pass_cnt++;
`else
      total_cnt++;
      if (!ok || blens.size() != 1 || blens[0] != 8 || starts[0] !== 32'h3F8)
         $display("FAIL t6_nosplit: blens=%p starts=%p want '{8} at 3f8", blens, starts);
      else pass_cnt++;
`endif
      total_cnt++;
      if (rx.size() != 8 || rx[7] !== ~32'h414)
         $display("FAIL t6_data: words=%0d want 8 ending at 414", rx.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_burst();
      bit seen_cyc = 0;
      ready = 1'b0;
      clear_mon();
      do_start(32'h6000, 16'd16);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wbm_cyc_o) begin
            seen_cyc = 1;
            break;
         end
      end
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (!seen_cyc || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || dout_valid_o !== 1'b0 ||
          busy_o !== 1'b0)
         $display("FAIL t7_async_reset: seen=%b cyc=%b stb=%b valid=%b busy=%b want 1 0 0 0 0",
                  seen_cyc, wbm_cyc_o, wbm_stb_o, dout_valid_o, busy_o);
      else pass_cnt++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle_cycles(3);
      total_cnt++;
      if (wbm_cyc_o !== 1'b0 || dout_valid_o !== 1'b0 || busy_o !== 1'b0)
         $display("FAIL t7_after_reset: cyc=%b valid=%b busy=%b want 0 0 0",
                  wbm_cyc_o, dout_valid_o, busy_o);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_bursts_20();
      test_backpressure();
      test_error();
      test_retry();
      test_short_counts();
      test_page_boundary();
      test_reset_mid_burst();
      total_cnt++;
      if (ovf_cnt != 0) $display("FAIL fifo_overflow: got %0d overflow cycles want 0", ovf_cnt);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
